// File: rtl/bls_pkg.sv
// Shared constants and helpers for the pipelined borrow-lookahead subtractor.
package bls_pkg;

    // Per-transaction operation select.
    localparam logic MODE_SUB = 1'b0;   // X - Y - Bin
    localparam logic MODE_ABS = 1'b1;   // |X - Y|

    // Number of lookahead groups, which is also the number of group stages.
    function automatic int unsigned num_groups(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    // Operand width must split evenly into whole lookahead groups.
    function automatic bit geometry_ok(input int unsigned width, input int unsigned group);
        return (group != 32'd0) && (width >= group) && ((width % group) == 32'd0);
    endfunction

endpackage

// File: rtl/bls_group.sv
// Combinational GROUP-bit borrow-lookahead cell: difference bits plus group borrow-out.
module bls_group
    import bls_pkg::*;
#(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] x,
    input  logic [GROUP-1:0] y,
    input  logic             b_in,
    output logic [GROUP-1:0] d,
    output logic             b_out
);

    logic [GROUP-1:0] g_s;      // bit generates a borrow
    logic [GROUP-1:0] p_s;      // bit propagates an incoming borrow
    logic [GROUP-1:0] bw_s;     // borrow into each bit of the group
    logic             grp_g_s;  // group generates a borrow on its own
    logic             grp_p_s;  // group passes b_in straight through

    assign g_s = ~x & y;
    assign p_s = ~(x ^ y);

    // Resolve in-group borrows, the difference bits and the group generate/propagate terms.
    always_comb begin
        bw_s    = {GROUP{1'b0}};
        grp_g_s = 1'b0;
        bw_s[0] = b_in;
        for (int i = 0; i < GROUP - 1; i++) begin
            bw_s[i+1] = g_s[i] | (p_s[i] & bw_s[i]);
        end
        for (int i = 0; i < GROUP; i++) begin
            grp_g_s = g_s[i] | (p_s[i] & grp_g_s);
        end
        grp_p_s = &p_s;
        d       = x ^ y ^ bw_s;
        b_out   = grp_g_s | (grp_p_s & b_in);
    end

endmodule

// File: rtl/bls_pipe.sv
// Pipelined borrow-lookahead subtractor: one GROUP-bit group resolved per stage,
// followed by a registered mode stage (plain subtract or absolute difference).
module bls_pipe
    import bls_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int unsigned NG = num_groups(WIDTH, GROUP);

    if (!geometry_ok(WIDTH, GROUP)) begin : g_geometry_check
        $fatal(1, "bls_pipe: WIDTH must be a non-zero multiple of GROUP");
    end

    logic             advance_s;   // whole pipe shifts this cycle
    logic [WIDTH-1:0] raw_s;       // difference leaving the last group stage
    logic             fin_b_s;     // final borrow
    logic             fin_mode_s;
    logic [WIDTH-1:0] fin_diff_s;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             out_valid_r;

    assign advance_s = ~out_valid_r | out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int unsigned RES_W = (k + 1) * GROUP;   // bits resolved once this stage loads

        logic [GROUP-1:0] cell_x_s;
        logic [GROUP-1:0] cell_y_s;
        logic [GROUP-1:0] cell_d_s;
        logic             cell_bin_s;
        logic             cell_bout_s;
        logic [RES_W-1:0] res_s;
        logic             mode_s;
        logic             valid_s;
        logic [RES_W-1:0] dif_r;     // difference groups 0..k
        logic             b_r;       // borrow into group k+1
        logic             mode_r;
        logic             v_r;

        if (k == 0) begin : g_src
            assign cell_x_s   = X[GROUP-1:0];
            assign cell_y_s   = Y[GROUP-1:0];
            assign cell_bin_s = (mode == MODE_ABS) ? 1'b0 : Bin;
            assign res_s      = cell_d_s;
            assign mode_s     = mode;
            assign valid_s    = in_valid;
        end else begin : g_src
            assign cell_x_s   = g_stage[k-1].g_ops.opx_r[GROUP-1:0];
            assign cell_y_s   = g_stage[k-1].g_ops.opy_r[GROUP-1:0];
            assign cell_bin_s = g_stage[k-1].b_r;
            assign res_s      = {cell_d_s, g_stage[k-1].dif_r};
            assign mode_s     = g_stage[k-1].mode_r;
            assign valid_s    = g_stage[k-1].v_r;
        end

        bls_group #(
            .GROUP (GROUP)
        ) u_group (
            .x     (cell_x_s),
            .y     (cell_y_s),
            .b_in  (cell_bin_s),
            .d     (cell_d_s),
            .b_out (cell_bout_s)
        );

        // Stage k result, borrow, mode and valid register; holds while the pipe is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                dif_r  <= {RES_W{1'b0}};
                b_r    <= 1'b0;
                mode_r <= 1'b0;
                v_r    <= 1'b0;
            end else if (advance_s) begin
                dif_r  <= res_s;
                b_r    <= cell_bout_s;
                mode_r <= mode_s;
                v_r    <= valid_s;
            end
        end

        // Operand groups still waiting to be resolved; the last stage has none left.
        if (k < NG - 1) begin : g_ops
            localparam int unsigned UP_W = WIDTH - RES_W;

            logic [UP_W-1:0] upx_s;
            logic [UP_W-1:0] upy_s;
            logic [UP_W-1:0] opx_r;
            logic [UP_W-1:0] opy_r;

            if (k == 0) begin : g_up
                assign upx_s = X[WIDTH-1:GROUP];
                assign upy_s = Y[WIDTH-1:GROUP];
            end else begin : g_up
                assign upx_s = g_stage[k-1].g_ops.opx_r[WIDTH-k*GROUP-1:GROUP];
                assign upy_s = g_stage[k-1].g_ops.opy_r[WIDTH-k*GROUP-1:GROUP];
            end

            // Unresolved upper operand register for stage k.
            always_ff @(posedge clk) begin
                if (rst) begin
                    opx_r <= {UP_W{1'b0}};
                    opy_r <= {UP_W{1'b0}};
                end else if (advance_s) begin
                    opx_r <= upx_s;
                    opy_r <= upy_s;
                end
            end
        end
    end

    assign raw_s      = g_stage[NG-1].dif_r;
    assign fin_b_s    = g_stage[NG-1].b_r;
    assign fin_mode_s = g_stage[NG-1].mode_r;

    // Apply the transaction mode: absolute difference negates a borrowed result.
    always_comb begin
        fin_diff_s = raw_s;
        case (fin_mode_s)
            MODE_SUB: fin_diff_s = raw_s;
            MODE_ABS: begin
                if (fin_b_s) begin
                    fin_diff_s = ~raw_s + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    fin_diff_s = raw_s;
                end
            end
            default:  fin_diff_s = raw_s;
        endcase
    end

    // Output register; holds the result stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r      <= {WIDTH{1'b0}};
            bout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (advance_s) begin
            diff_r      <= fin_diff_s;
            bout_r      <= fin_b_s;
            out_valid_r <= g_stage[NG-1].v_r;
        end
    end

    assign Diff      = diff_r;
    assign Bout      = bout_r;
    assign out_valid = out_valid_r;

endmodule
